// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Sequencer/controller for an event counter. A configuration (terminal
//   limit, prescale divisor, one-shot/periodic mode) is latched through a
//   valid/ready handshake. start/stop commands move the counter through
//   RUN, HOLD and DONE. A registered one-cycle tc_pulse marks every
//   arrival at the terminal count.
//
//   Handshake: a configuration transfer happens on a rising clk edge where
//   cfg_valid and cfg_ready are both high. cfg_ready depends on state only
//   (high in IDLE and DONE). The master keeps cfg_valid and the cfg_* fields
//   stable until the transfer happens.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   re            asynchronous active-low reset
//   cfg_valid     configuration offered
//   cfg_ready     configuration accepted this cycle when high with cfg_valid
//   cfg_limit     terminal count value
//   cfg_prescale  clock cycles per count tick, minus one
//   cfg_mode      0 = one-shot, 1 = periodic
//   start         start / resume command
//   stop          pause / abort command (wins over start)
//   count         current count value, registered
//   tc_pulse      one-cycle pulse when count reaches limit
//   busy          high in RUN or HOLD
//   done          high in DONE
//   dbg_state     current FSM state (IDLE=0, RUN=1, HOLD=2, DONE=3)
module counter_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [WIDTH-1:0]      cfg_limit,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_mode,
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [WIDTH-1:0]        count_q,    count_d;
    logic [PRESCALE_W-1:0]   pre_q,      pre_d;
    logic [WIDTH-1:0]        limit_q,    limit_d;
    logic [PRESCALE_W-1:0]   prescale_q, prescale_d;
    logic                    mode_q,     mode_d;
    logic                    tc_q,       tc_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;

    logic                    cfg_hs;

    assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
    assign cfg_hs    = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_d      = pre_q;
        tc_d       = 1'b0;

        // A handshake in the same cycle as start is already visible here,
        // so the start check below sees the freshly offered configuration.
        limit_d    = cfg_hs ? cfg_limit    : limit_q;
        prescale_d = cfg_hs ? cfg_prescale : prescale_q;
        mode_d     = cfg_hs ? cfg_mode     : mode_q;

        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (start && (limit_d != '0)) begin
                    state_d = RUN;
                    count_d = '0;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = HOLD;
                end else if (pre_q == prescale_q) begin
                    pre_d = '0;
                    if (count_q == limit_q) begin
                        // Periodic wrap; one-shot never gets here.
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                        if ((count_q + 1'b1) == limit_q) begin
                            tc_d = 1'b1;
                            if (!mode_q) begin
                                state_d = DONE;
                            end
                        end
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (start) begin
                    // Resume from the frozen count and prescale phase.
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                pre_d   = '0;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pre_q      <= '0;
            limit_q    <= '0;
            prescale_q <= '0;
            mode_q     <= 1'b0;
            tc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            limit_q    <= limit_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            tc_q       <= tc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign count     = count_q;
    assign tc_pulse  = tc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
